// File: rtl/bullet_scheduler_pkg.sv
// bullet_scheduler_pkg: shared game widths, scheduler FSM states and bullet idle constants.
package bullet_scheduler_pkg;
  localparam int X_W = 5;
  localparam int Y_W = 4;
  localparam logic [Y_W-1:0] BULLET_Y_RESET = 4'd15;
  localparam logic [Y_W-1:0] BULLET_Y_EXPIRE = 4'd14;
  typedef enum logic {S_IDLE = 1'b0, S_FIRE = 1'b1} state_e;
endpackage

// File: rtl/bullet_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, searches upward from ptr_i with wrap.
module rr_arbiter #(
  parameter int W = 4,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [W-1:0]  gnt_o,
  output logic          valid_o
);
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < W; i++) begin
      int idx;
      idx = (int'(ptr_i) + i) % W;
      if (req_i[idx[PW-1:0]] && gnt_o == '0) gnt_o[idx[PW-1:0]] = 1'b1;
    end
    valid_o = |req_i;
  end
endmodule

// File: rtl/bullet_scheduler.sv
// bullet_scheduler: hands free bullet slots to ship/alien fire requests with per-requester cooldown.
// Define BULLET_SCHED_PLAYER_PRIO_EN to give requester 0 absolute priority.
module bullet_scheduler
  import bullet_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_SLOTS = 2,
  parameter int COOLDOWN = 2500000
) (
  input  logic                     i_clk_25MHz,
  input  logic                     i_reset_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [X_W*NUM_REQ-1:0]   i_req_x,
  input  logic [NUM_SLOTS-1:0]     i_slot_done,
  output logic [NUM_SLOTS-1:0]     o_shoot,
  output logic [X_W-1:0]           o_shot_x,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_SLOTS-1:0]     o_slot_busy
);
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_nx;
  logic [NUM_REQ-1:0][CW-1:0] cd_q, cd_d;
  logic [NUM_SLOTS-1:0] busy_q, busy_d, shoot_q, shoot_d, slot;
  logic [NUM_REQ-1:0] grant_q, grant_d, elig, rr_req, rr_gnt, win;
  logic [X_W-1:0] x_q, x_d, win_x;
  logic rr_valid, any_win, fire, ptr_hold;
  always_comb
    for (int k = 0; k < NUM_REQ; k++) elig[k] = i_req[k] && cd_q[k] == '0;
`ifdef BULLET_SCHED_PLAYER_PRIO_EN
  // The player bypasses the ring; aliens share it without disturbing it on player shots.
  assign rr_req = elig & ~NUM_REQ'(1);
  assign win = elig[0] ? NUM_REQ'(1) : rr_gnt;
  assign any_win = elig[0] | rr_valid;
  assign ptr_hold = elig[0];
`else
  assign rr_req = elig;
  assign win = rr_gnt;
  assign any_win = rr_valid;
  assign ptr_hold = 1'b0;
`endif
  rr_arbiter #(.W(NUM_REQ), .PW(PW)) u_arb (
    .req_i(rr_req), .ptr_i(ptr_q), .gnt_o(rr_gnt), .valid_o(rr_valid)
  );
  always_comb begin
    slot = '0;
    for (int s = 0; s < NUM_SLOTS; s++) if (!busy_q[s] && slot == '0) slot[s] = 1'b1;
    win_x = '0;
    ptr_nx = ptr_q;
    for (int k = 0; k < NUM_REQ; k++)
      if (win[k]) begin
        win_x = i_req_x[X_W*k +: X_W];
        ptr_nx = PW'((k + 1) % NUM_REQ);
      end
  end
  // Freedom is judged on registered occupancy only, so a done pulse never frees a slot the same cycle.
  always_comb begin
    fire = state_q == S_IDLE && any_win && !(&busy_q);
    state_d = fire ? S_FIRE : S_IDLE;
    ptr_d = (fire && !ptr_hold) ? ptr_nx : ptr_q;
    busy_d = (busy_q & ~i_slot_done) | (fire ? slot : '0);
    shoot_d = fire ? slot : '0;
    grant_d = fire ? win : '0;
    x_d = fire ? win_x : '0;
    for (int k = 0; k < NUM_REQ; k++)
      cd_d[k] = (fire && win[k]) ? CD_LOAD : (cd_q[k] != '0 ? cd_q[k] - 1'b1 : cd_q[k]);
  end
  always_ff @(posedge i_clk_25MHz or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      cd_q <= '0;
      busy_q <= '0;
      shoot_q <= '0;
      grant_q <= '0;
      x_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cd_q <= cd_d;
      busy_q <= busy_d;
      shoot_q <= shoot_d;
      grant_q <= grant_d;
      x_q <= x_d;
    end
  assign o_shoot = shoot_q;
  assign o_grant = grant_q;
  assign o_shot_x = x_q;
  assign o_slot_busy = busy_q;
endmodule

// File: tb/tb_bullet_scheduler.sv
// tb_bullet_scheduler: directed checks of grant timing, cooldown, slot recycling and async reset.
module tb_bullet_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [19:0] req_x;
  logic [1:0] done;
  logic [1:0] shoot, busy;
  logic [4:0] shot_x;
  logic [3:0] grant;
  int total = 0;
  int bad = 0;
  bullet_scheduler #(.NUM_REQ(4), .NUM_SLOTS(2), .COOLDOWN(8)) dut (
    .i_clk_25MHz(clk), .i_reset_n(rst_n), .i_req(req), .i_req_x(req_x),
    .i_slot_done(done), .o_shoot(shoot), .o_shot_x(shot_x), .o_grant(grant),
    .o_slot_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [1:0] s, input logic [3:0] g,
                         input logic [4:0] x, input logic [1:0] b);
    chk({tag, ".shoot"}, 32'(shoot), 32'(s));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".x"}, 32'(shot_x), 32'(x));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask
  initial begin
    rst_n = 1'b0;
    req = '0;
    req_x = {5'd30, 5'd9, 5'd3, 5'd17};
    done = '0;
    repeat (3) tick();
    chk_out("rst_hold", 2'b00, 4'b0000, 5'd0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk_out("idle", 2'b00, 4'b0000, 5'd0, 2'b00);
    req = 4'b0001;
    tick();
    chk_out("p0_first", 2'b01, 4'b0001, 5'd17, 2'b01);
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk($sformatf("p0_cool%0d", i), 32'(shoot), 32'd0);
    end
    tick();
    chk_out("p0_second", 2'b10, 4'b0001, 5'd17, 2'b11);
    req = '0;
    repeat (8) tick();
    chk_out("full_quiet", 2'b00, 4'b0000, 5'd0, 2'b11);
    req = 4'b0001;
    done = 2'b10;
    tick();
    chk_out("done1_clear", 2'b00, 4'b0000, 5'd0, 2'b01);
    done = 2'b00;
    tick();
    chk_out("refill1", 2'b10, 4'b0001, 5'd17, 2'b11);
    req = 4'b1110;
    done = 2'b11;
    tick();
    chk_out("free_all", 2'b00, 4'b0000, 5'd0, 2'b00);
    done = 2'b00;
    tick();
    chk_out("rr_r1", 2'b01, 4'b0010, 5'd3, 2'b01);
    tick();
    chk_out("rr_gap", 2'b00, 4'b0000, 5'd0, 2'b01);
    tick();
    chk_out("rr_r2", 2'b10, 4'b0100, 5'd9, 2'b11);
    repeat (3) tick();
    chk_out("rr_full", 2'b00, 4'b0000, 5'd0, 2'b11);
    done = 2'b01;
    tick();
    chk_out("rr_done0", 2'b00, 4'b0000, 5'd0, 2'b10);
    done = 2'b00;
    tick();
    chk_out("rr_r3", 2'b01, 4'b1000, 5'd30, 2'b11);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 2'b00, 4'b0000, 5'd0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0001;
    tick();
    chk_out("post_rst", 2'b01, 4'b0001, 5'd17, 2'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Shares a fixed pool of bullet instances among several fire requesters: the player ship and the alien shooters. It arbitrates the requests, picks a free bullet slot, and issues a one-cycle shoot pulse plus the launch x-coordinate to that slot. It tracks slot occupancy from per-slot done pulses and enforces a per-requester cooldown. It sits between the game logic (ship/alien controllers) and the array of bullet instances.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; index 0 is the player ship
- NUM_SLOTS, 2, number of bullet instances managed
- COOLDOWN, 2500000, cycles a requester is blocked after a grant (0.1 s at 25 MHz); range 1..2^24-1

Ports:
- i_clk_25MHz  in  1  system clock
- i_reset_n  in  1  reset, asynchronous assert, active-low
- i_req  in  NUM_REQ  level fire request per requester
- i_req_x  in  5*NUM_REQ  launch x per requester; requester k occupies bits [5k+4:5k]
- i_slot_done  in  NUM_SLOTS  one-cycle pulse: slot's bullet hit something or left the screen
- o_shoot  out  NUM_SLOTS  one-hot, one-cycle shoot pulse to the chosen slot
- o_shot_x  out  5  launch x, valid while any o_shoot bit is high; shared by all slots
- o_grant  out  NUM_REQ  one-hot, one-cycle, coincident with o_shoot; identifies the winning requester
- o_slot_busy  out  NUM_SLOTS  occupancy bitmap

## Operation
- Reset (i_reset_n low, asynchronous):
  - o_shoot, o_grant, o_slot_busy, o_shot_x all 0.
  - All cooldown counters 0.
  - Round-robin pointer 0; state S_IDLE.
- Eligibility:
  - elig[k] = i_req[k] and cooldown[k]==0.
  - A free slot exists when o_slot_busy is not all ones.
- FSM states:
  - S_IDLE: if any elig and a free slot exists, grant and go to S_FIRE; otherwise stay.
  - S_FIRE: the outputs of the grant are high for exactly this cycle. Go to S_IDLE unconditionally; no arbitration happens in this state.
- Grant actions, registered on the S_IDLE→S_FIRE edge:
  - The winner k is picked round-robin, searching from the pointer upward with wrap.
  - The slot s is the lowest-index free slot.
  - o_shoot[s]=1, o_grant[k]=1, o_shot_x=i_req_x[k], busy[s]=1, cooldown[k]=COOLDOWN.
  - The pointer becomes (k+1) mod NUM_REQ.
- Cooldown:
  - A nonzero counter decrements by 1 every cycle, starting the cycle after it loads.
  - It saturates at 0.
  - Counter width is clog2(COOLDOWN+1).
- Slot release:
  - i_slot_done[s] clears busy[s] on the next edge.
  - A done pulse for a slot that is not busy is ignored.
  - Done and grant on the same slot cannot coincide, because a granted slot was free. Done on slot a and grant on slot b in the same cycle both take effect.
  - A slot freed by done becomes eligible for arbitration one cycle after the clearing edge. It is never considered in the cycle the pulse is present.
- Requests are level-sensitive. A held request re-fires once the cooldown expires and a slot is free. A request dropped before the grant is not remembered.
- An asynchronous reset mid-S_FIRE drops the pulse immediately. The bullets must be reset by the same reset.

## Timing
- Edge t: S_IDLE sampling elig≠0 with a free slot → after edge t+1: o_shoot/o_grant/o_shot_x valid for one cycle.
- Edge t+2: outputs return to 0, state S_IDLE.
- Earliest next grant is on edge t+3, giving a minimum issue spacing of 2 cycles.
- A requester granted at edge t is next eligible for sampling at edge t+1+COOLDOWN.
- i_slot_done sampled at edge d → busy clear visible after edge d+1 → earliest grant into that slot at edge d+2.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- BULLET_SCHED_PLAYER_PRIO_EN defined:
  - Requester 0 has fixed absolute priority whenever it is eligible.
  - The round-robin pointer is not updated on player grants.
  - Requesters 1..NUM_REQ-1 round-robin among themselves.
- BULLET_SCHED_PLAYER_PRIO_EN undefined: pure round-robin over all NUM_REQ requesters.

## Structure
- Shared game package/include holds:
  - coordinate widths (X_W=5, Y_W=4);
  - FSM state encodings S_IDLE/S_FIRE;
  - the bullet idle constants (y=15 reset, y=14 expire).
- One natural sub-module is rr_arbiter, a combinational round-robin picker. It takes request vector and pointer and returns a one-hot winner plus a valid flag. It is parameterised by width and reused for alien-group scheduling.
- Slot selection is a lowest-zero finder, inline.

## Test plan
Use NUM_REQ=4, NUM_SLOTS=2, COOLDOWN=8.

1. Reset held, then released with i_req=0 → all outputs 0 indefinitely; o_slot_busy=2'b00.
2. i_req=4'b0001, i_req_x[4:0]=17 from edge 0 → o_shoot=2'b01, o_grant=4'b0001, o_shot_x=17 after edge 1 for one cycle. o_slot_busy=2'b01. Next grant to requester 0 is to slot 1 after edge 10.
3. i_req=4'b1110 held, slots free (macro off) → grants to requesters 1, 2 fill slots 0 and 1, two cycles apart. Then no grant until i_slot_done=2'b01. The slot-0 grant goes to requester 3 two edges after the done pulse is sampled.
4. Slots full, i_slot_done[1] pulsed while i_req=4'b0001 → busy[1] clears next edge; o_shoot=2'b10 one edge later.
5. BULLET_SCHED_PLAYER_PRIO_EN defined, i_req=4'b1111, COOLDOWN=1, slots recycled by immediate done pulses → requester 0 wins every grant for which it is eligible. The others win only while requester 0 is in cooldown.
6. i_reset_n pulled low mid-S_FIRE, asynchronously to the clock → o_shoot, o_grant, o_slot_busy read 0 immediately, before the next clock edge.
